// File: rtl/axi_pkg.sv
// Shared AXI types for the instruction-memory read slave and its helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Byte mask of a WRAP container: (len+1) beats of 2^size bytes, minus one.
  function automatic logic [31:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
    return ((32'(len) + 32'd1) << size) - 32'd1;
  endfunction

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_imem_rd_slave_if.sv
// AR/R channel bundle between the instruction-fetch master and the memory slave.
// Latency: none (wires only).
// Backpressure: standard valid/ready on both AR and R channels.
interface axi_imem_rd_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [1:0]        arburst;
  logic [2:0]        arsize;
  logic [7:0]        arlen;
  logic [3:0]        arcache;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, arburst, arsize, arlen, arcache, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arvalid, arburst, arsize, arlen, arcache, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for FIXED / INCR / WRAP AXI bursts.
// Latency: purely combinational.
// Backpressure: none; caller decides when to advance.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] mask;

  // Align to the beat size, step one beat, and fold back into the container for WRAP.
  always_comb begin
    step      = ADDR_W'(1) << size;
    incr_addr = (addr & ~(step - ADDR_W'(1))) + step;
    mask      = ADDR_W'(wrap_mask(len, size));
    next_addr = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~mask) | (incr_addr & mask);
      default: next_addr = addr;  // FIXED, and reserved bursts whose data is forced to zero anyway
    endcase
  end
endmodule

// File: rtl/axi_imem_rd_slave.sv
// AXI4 read-only instruction memory: one burst at a time, 64-bit beats from a preloadable array.
// Latency: first beat registered 1 cycle after the AR handshake, then one beat per cycle.
// Backpressure: R outputs held while rvalid & !rready; arready low for the whole burst.
module axi_imem_rd_slave
  import axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                MEM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axi_imem_rd_slave_if.slave           bus,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [DATA_W-1:0]            ld_data
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q, cnt_q;
  logic [1:0]        burst_q;
  logic [2:0]        size_q;
  logic              slverr_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic              ar_hs, r_adv, r_done;
  logic              slverr_new;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] beat_addr, beat_off, beat_idx;
  logic              beat_slverr, beat_decerr;
  logic [DATA_W-1:0] beat_dat;
  logic [1:0]        beat_resp;

  // Cache attributes have no meaning for a plain array.
  logic unused_arcache;
  assign unused_arcache = ^bus.arcache;

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Preload port writes regardless of state; a beat reading the same word this edge sees old data.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Burst-wide error: illegal size, reserved burst type, or WRAP with an unsupported length.
  always_comb begin
    slverr_new = (bus.arsize > 3'd3) || (bus.arburst == 2'b11) ||
                 ((bus.arburst == WRAP) && !wrap_len_ok(bus.arlen));
  end

  // Beat being registered next: the AR start address in IDLE, the advanced address in BURST.
  always_comb begin
    beat_addr   = (state_q == IDLE) ? bus.araddr : next_addr;
    beat_slverr = (state_q == IDLE) ? slverr_new : slverr_q;
    beat_off    = beat_addr - BASE_ADDR;
    beat_idx    = beat_off >> 3;
    beat_decerr = (beat_addr < BASE_ADDR) || (beat_idx >= ADDR_W'(MEM_WORDS));
    beat_resp   = beat_slverr ? RESP_SLVERR : (beat_decerr ? RESP_DECERR : RESP_OKAY);
    beat_dat    = (beat_slverr || beat_decerr) ? '0 : mem[beat_idx[IDX_W-1:0]];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake decode.
  always_comb begin
    state_d = state_q;
    ar_hs   = 1'b0;
    r_adv   = 1'b0;
    r_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.arvalid && arready_q) begin
          ar_hs   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (rvalid_q && bus.rready) begin
          if (rlast_q) begin
            r_done  = 1'b1;
            state_d = IDLE;
          end else begin
            r_adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst context, beat counter and registered R channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      size_q    <= '0;
      slverr_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (ar_hs) begin
      addr_q    <= bus.araddr;
      len_q     <= bus.arlen;
      cnt_q     <= '0;
      burst_q   <= bus.arburst;
      size_q    <= bus.arsize;
      slverr_q  <= slverr_new;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rlast_q   <= (bus.arlen == 8'd0);
      rdata_q   <= beat_dat;
      rresp_q   <= beat_resp;
    end else if (r_adv) begin
      addr_q  <= next_addr;
      cnt_q   <= cnt_q + 8'd1;
      rlast_q <= ((cnt_q + 8'd1) == len_q);
      rdata_q <= beat_dat;
      rresp_q <= beat_resp;
    end else if (r_done) begin
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b1;
    end else if (state_q == IDLE) begin
      arready_q <= 1'b1;  // first edge after reset release
    end
  end
endmodule

// File: doc/axi_imem_rd_slave.md
Name: axi_imem_rd_slave

Overview:
- AXI4 read-only responder (slave) serving the core's instruction-fetch read master: AR channel in, R channel out, 64-bit data.
- Backed by an internal word-addressed array, preloaded through a simple load port.
- Testbenches and FPGA top-level use it as the instruction memory attached to the core's I-port.
- One outstanding burst at a time; returns one beat per cycle when rready is held high.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, R data width; fixed at 64 for this block
- MEM_WORDS, 4096, array depth in 64-bit words
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- araddr  in  32  burst start byte address
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arsize  in  3  log2 bytes per beat
- arlen  in  8  beats minus 1
- arcache  in  4  accepted and ignored
- rdata  out  64  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  final beat of burst
- rvalid  out  1  R valid
- rready  in  1  R ready
- ld_en  in  1  preload write strobe
- ld_addr  in  clog2(MEM_WORDS)  preload word index
- ld_data  in  64  preload word

Behaviour:
- Reset values: arready=0, rvalid=0, rlast=0, rresp=00, rdata=0, state=IDLE. Array contents are not reset.
- arready rises on the first clock edge after rst_n deasserts.
- States:
  - IDLE: arready=1. On arvalid&arready at edge T, latch addr/len/burst/size, arready->0, go BURST.
  - BURST: beat 0 is valid from edge T+1, so latency is 1 cycle from AR handshake to first rvalid. After an R handshake (rvalid&rready) on a non-last beat, the next beat is registered at that same edge; rvalid stays 1 with no bubble. rdata/rresp/rlast are held stable while rvalid&!rready. On the last-beat handshake: rvalid->0, arready->1, go IDLE. The next AR is accepted at the earliest one cycle later; there is no AR/R overlap.
- Beat counter counts 0..arlen. rlast=1 exactly when count==arlen. arlen=0 gives a single beat with rlast=1.
- Next address (arithmetic in ADDR_W, wraps modulo 2^32):
  - FIXED: unchanged.
  - INCR: (addr & ~(2^size-1)) + 2^size.
  - WRAP: container = (arlen+1)*2^size, aligned to the container; crossing the top returns to the container base.
- Data:
  - Word index = (addr - BASE_ADDR) >> 3.
  - rdata is always the full aligned 64-bit word; the master selects the byte lanes for narrow sizes.
- Error responses, evaluated per beat:
  - Word index >= MEM_WORDS, or addr < BASE_ADDR: DECERR, rdata=0.
  - Burst-wide SLVERR, rdata=0, with the beat count still honoured: arsize>3, arburst=11, or WRAP with arlen not in {1,3,7,15}.
  - SLVERR takes precedence over DECERR.
- Preload:
  - ld_en writes the array at the clock edge, in any state.
  - If a beat samples the same word on the same edge, that beat carries the old data; the new data is visible from the next edge.
- Reset mid-burst: all R outputs drop immediately (async). The burst is abandoned, with no residual beats after reset release.
- arvalid while busy is ignored (arready=0); the master holds it.

Decomposition:
- Package axi_pkg holds:
  - burst enum {FIXED, INCR, WRAP}
  - resp constants OKAY/EXOKAY/SLVERR/DECERR
  - state enum {IDLE, BURST}
  - function wrap_mask(len,size)
- Natural sub-module: axi_burst_addr_gen, combinational next-address calculator taking addr, size, len and burst; reusable by the data-port slave later.

Test Plan:
- Preload words 0..7 = 64'h1000+i. AR araddr=0x0, arlen=3, INCR, size=3, rready=1. AR handshake at T; beats at T+1..T+4 return 0x1000..0x1003, rlast only on T+4, rresp=00.
- WRAP: araddr=0x28, arlen=3, size=3. Word order 5,6,7,4 (bytes 0x28,0x30,0x38,0x20).
- Backpressure: arlen=1, rready low 3 cycles after the first rvalid. rdata=0x1000 and rlast=0 are held stable; the second beat follows the cycle after rready=1.
- Errors:
  - araddr=MEM_WORDS*8 with arlen=0: one beat DECERR, rdata=0, rlast=1.
  - arsize=4 with arlen=2: three SLVERR beats.
- Load/read collision: ld_en writes word 2 = 0xDEAD on the same edge beat 2 of an INCR burst from 0 is registered. The beat returns 0x1002; a re-read returns 0xDEAD.
- rst_n low during beat 1 of arlen=7: rvalid=0 asynchronously. After release, arready=1 next edge, no R beats, array contents intact.
